// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its word array.
package dmem_pkg;

    localparam int OFFSET_W   = 3;
    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 9;
    localparam int IDX_W_DEF  = ADDR_W_DEF - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_e;

    // Request captured at the accept edge; fields sized for the default geometry.
    typedef struct packed {
        op_e                   op;
        logic [IDX_W_DEF-1:0]  idx;
        logic [DATA_W_DEF-1:0] data;
    } req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, combinational read, no reset.
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the load/store interface: one request at a time,
// fixed access latency, response returned over its own valid/ready handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              resp_err
);

    localparam int IDX_W = ADDR_W - OFFSET_W;
    localparam int DEPTH = 2 ** IDX_W;
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              resp_err_q, resp_err_d;

    logic              legal;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    assign legal = (MemRead ^ MemWrite) && (addr[OFFSET_W-1:0] == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        resp_valid_d = resp_valid_q;
        rd_data_d    = rd_data_q;
        resp_err_d   = resp_err_q;
        arr_we       = 1'b0;
        req_ready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (legal) begin
                        req_d.op   = MemWrite ? OP_STORE : OP_LOAD;
                        req_d.idx  = addr[ADDR_W-1:OFFSET_W];
                        req_d.data = wr_data;
                        cnt_d      = CNT_W'(LATENCY - 1);
                        state_d    = WAIT;
                    end else begin
                        // Illegal requests never touch the array and answer immediately.
                        rd_data_d    = '0;
                        resp_err_d   = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    if (req_q.op == OP_STORE) begin
                        arr_we    = 1'b1;
                        rd_data_d = '0;
                    end else begin
                        rd_data_d = arr_rdata;
                    end
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            rd_data_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            rd_data_q    <= rd_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign rd_data    = rd_data_q;
    assign resp_err   = resp_err_q;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (req_q.idx),
        .wdata (req_q.data),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus hand-written
// stall and reset sequences, with a scoreboard of expected responses.
module tb_dmem_responder;

    localparam int DATA_W   = 64;
    localparam int ADDR_W   = 9;
    localparam int LATENCY  = 2;
    localparam int MAX_WAIT = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] rd_data;
    logic              resp_err;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [DATA_W-1:0] rd_data;
        logic              err;
    } exp_t;

    typedef struct {
        string             name;
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_rd;
        logic              exp_err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    dmem_responder #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .MemRead    (mem_read),
        .MemWrite   (mem_write),
        .addr       (addr),
        .wr_data    (wr_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .rd_data    (rd_data),
        .resp_err   (resp_err)
    );

    task automatic check_output(input string name, input logic [DATA_W-1:0] actual,
                                input logic [DATA_W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one request and waits for resp_valid; the response itself is left pending.
    task automatic apply_stimulus(input string name, input logic rd, input logic wr,
                                  input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                  input logic [DATA_W-1:0] exp_rd, input logic exp_err);
        int waited = 0;
        int lat    = 0;
        while (!req_ready && waited < MAX_WAIT) begin
            @(posedge clk); #1;
            waited++;
        end
        check_output({name, " req_ready"}, DATA_W'(req_ready), DATA_W'(1));
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wr_data   = d;
        sb_q.push_back('{rd_data: exp_rd, err: exp_err});
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        addr      = ADDR_W'($urandom);
        wr_data   = {$urandom, $urandom};
        check_output({name, " busy"}, DATA_W'(req_ready), DATA_W'(0));
        while (!resp_valid && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
        end
        // Illegal requests respond at the accept edge itself, so no further edges.
        check_output({name, " latency"}, DATA_W'(lat), exp_err ? DATA_W'(0) : DATA_W'(LATENCY));
    endtask

    task automatic collect_response(input string name);
        exp_t e;
        check_output({name, " resp_valid"}, DATA_W'(resp_valid), DATA_W'(1));
        if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", name);
        end else begin
            e = sb_q.pop_front();
            check_output({name, " rd_data"}, rd_data, e.rd_data);
            check_output({name, " resp_err"}, DATA_W'(resp_err), DATA_W'(e.err));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check_output({name, " resp_done"}, DATA_W'(resp_valid), DATA_W'(0));
    endtask

    initial begin
        vecs.push_back('{"wr_010", 1'b0, 1'b1, 9'h010, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0});
        vecs.push_back('{"rd_010", 1'b1, 1'b0, 9'h010, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0});
        vecs.push_back('{"rd_013_misaligned", 1'b1, 1'b0, 9'h013, 64'h0, 64'h0, 1'b1});
        vecs.push_back('{"rd_010_after_mis", 1'b1, 1'b0, 9'h010, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0});
        vecs.push_back('{"both_010", 1'b1, 1'b1, 9'h010, 64'h5, 64'h0, 1'b1});
        vecs.push_back('{"rd_010_after_both", 1'b1, 1'b0, 9'h010, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0});
        vecs.push_back('{"none_010", 1'b0, 1'b0, 9'h010, 64'h7, 64'h0, 1'b1});
        vecs.push_back('{"rd_010_after_none", 1'b1, 1'b0, 9'h010, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0});
        vecs.push_back('{"wr_000", 1'b0, 1'b1, 9'h000, 64'hA, 64'h0, 1'b0});
        vecs.push_back('{"wr_1f8", 1'b0, 1'b1, 9'h1F8, 64'hB, 64'h0, 1'b0});
        vecs.push_back('{"rd_000", 1'b1, 1'b0, 9'h000, 64'h0, 64'hA, 1'b0});
        vecs.push_back('{"rd_1f8", 1'b1, 1'b0, 9'h1F8, 64'h0, 64'hB, 1'b0});
        vecs.push_back('{"wr_018", 1'b0, 1'b1, 9'h018, 64'h1234, 64'h0, 1'b0});
        vecs.push_back('{"wr_020", 1'b0, 1'b1, 9'h020, 64'h1, 64'h0, 1'b0});
        vecs.push_back('{"wr_024_misaligned", 1'b0, 1'b1, 9'h024, 64'h99, 64'h0, 1'b1});
        vecs.push_back('{"rd_020", 1'b1, 1'b0, 9'h020, 64'h0, 64'h1, 1'b0});

        reset      = 1'b1;
        req_valid  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        addr       = '0;
        wr_data    = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset req_ready", DATA_W'(req_ready), DATA_W'(1));
        check_output("reset resp_valid", DATA_W'(resp_valid), DATA_W'(0));
        check_output("reset rd_data", rd_data, DATA_W'(0));
        check_output("reset resp_err", DATA_W'(resp_err), DATA_W'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].addr,
                           vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err);
            collect_response(vecs[i].name);
        end

        // Stalled response: outputs stay put and a stray write request is ignored.
        apply_stimulus("stall_rd_010", 1'b1, 1'b0, 9'h010, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                req_valid = 1'b1;
                mem_read  = 1'b0;
                mem_write = 1'b1;
                addr      = 9'h018;
                wr_data   = 64'hFFFF;
            end
            if (i == 3) begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            check_output("stall resp_valid", DATA_W'(resp_valid), DATA_W'(1));
            check_output("stall rd_data", rd_data, 64'hDEADBEEFCAFEF00D);
            check_output("stall resp_err", DATA_W'(resp_err), DATA_W'(0));
            check_output("stall req_ready", DATA_W'(req_ready), DATA_W'(0));
        end
        req_valid = 1'b0;
        collect_response("stall_rd_010");
        apply_stimulus("rd_018_after_stall", 1'b1, 1'b0, 9'h018, 64'h0, 64'h1234, 1'b0);
        collect_response("rd_018_after_stall");

        // Reset in the first WAIT cycle of a store: the store must be dropped.
        check_output("rst_wait req_ready", DATA_W'(req_ready), DATA_W'(1));
        req_valid = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        addr      = 9'h020;
        wr_data   = 64'hFF;
        sb_q.push_back('{rd_data: 64'h0, err: 1'b0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_output("rst_wait in_wait", DATA_W'(req_ready), DATA_W'(0));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rst_wait resp_valid", DATA_W'(resp_valid), DATA_W'(0));
        check_output("rst_wait req_ready_async", DATA_W'(req_ready), DATA_W'(1));
        check_output("rst_wait rd_data", rd_data, DATA_W'(0));
        sb_q.delete();
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus("rd_020_after_rst", 1'b1, 1'b0, 9'h020, 64'h0, 64'h1, 1'b0);
        collect_response("rd_020_after_rst");

        // Reset while a response is pending drops it but keeps the array.
        apply_stimulus("rst_resp_rd_000", 1'b1, 1'b0, 9'h000, 64'h0, 64'hA, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("rst_resp resp_valid", DATA_W'(resp_valid), DATA_W'(0));
        check_output("rst_resp req_ready", DATA_W'(req_ready), DATA_W'(1));
        sb_q.delete();
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        apply_stimulus("rd_1f8_after_rst", 1'b1, 1'b0, 9'h1F8, 64'h0, 64'hB, 1'b0);
        collect_response("rd_1f8_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
